// File: rtl/alu_op_issue.sv
// ============================================================================
// Module  : alu_op_issue
// Brief   : RV32I OP/OP-IMM decode feeding the ALU through a 2-entry skid buffer
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [6:0] c_OPC_OP    = 7'b0110011;
  localparam logic [6:0] c_OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] c_F7_ZERO   = 7'b0000000;
  localparam logic [6:0] c_F7_ALT    = 7'b0100000;
  localparam int         c_ENTRY_W   = 80;

  // Entry layout: {illegal, rd, funct7, funct3, in2, in1}
  logic [c_ENTRY_W-1:0] r_m;
  logic [c_ENTRY_W-1:0] r_s;
  logic [1:0]           r_state;
  logic                 r_in_ready;

  logic [6:0]           w_opcode;
  logic [2:0]           w_funct3;
  logic [6:0]           w_funct7;
  logic                 w_legal;
  logic [31:0]          w_in1;
  logic [31:0]          w_in2;
  logic [2:0]           w_f3;
  logic [6:0]           w_f7;
  logic [c_ENTRY_W-1:0] w_dec;
  logic                 w_is_shift;
  logic                 w_unused_ok;

  logic                 w_acc;
  logic                 w_con;
  logic [1:0]           w_state_nxt;
  logic                 w_load_m;
  logic                 w_m_from_s;
  logic                 w_load_s;
  logic [c_ENTRY_W-1:0] w_m_nxt;

  assign w_opcode    = instr[6:0];
  assign w_funct3    = instr[14:12];
  assign w_funct7    = instr[31:25];
  assign w_is_shift  = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
  // Register index fields are resolved upstream; only the values arrive here.
  assign w_unused_ok = ^instr[19:15];

  always_comb begin
    w_legal = 1'b0;
    w_in1   = rs1_val;
    w_in2   = rs2_val;
    w_f3    = w_funct3;
    w_f7    = c_F7_ZERO;
    case (w_opcode)
      c_OPC_OP: begin
        w_f7 = w_funct7;
        case (w_funct7)
          c_F7_ZERO: w_legal = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
          c_F7_ALT:  w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);
          default:   w_legal = 1'b0;
        endcase
      end
      c_OPC_OPIMM: begin
        case (w_funct3)
          3'b001: begin
            w_in2   = {27'd0, instr[24:20]};
            w_legal = (w_funct7 == c_F7_ZERO);
          end
          3'b101: begin
            w_in2   = {27'd0, instr[24:20]};
            w_f7    = w_funct7;
            w_legal = (w_funct7 == c_F7_ZERO) || (w_funct7 == c_F7_ALT);
          end
          3'b010, 3'b011: begin
            w_legal = 1'b0;
          end
          default: begin
            w_in2   = {{20{instr[31]}}, instr[31:20]};
            w_legal = 1'b1;
          end
        endcase
      end
      default: w_legal = 1'b0;
    endcase

    // The ALU shifts by the full operand, so RV32 shift amounts are clipped here.
    if (w_is_shift) begin
      w_in2[31:5] = 27'd0;
    end

    if (!w_legal) begin
      w_in1 = 32'd0;
      w_in2 = 32'd0;
      w_f3  = 3'b000;
      w_f7  = c_F7_ZERO;
    end
  end

  assign w_dec = {~w_legal, instr[11:7], w_f7, w_f3, w_in2, w_in1};

  assign w_acc = in_valid && in_ready;
  assign w_con = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_m    = 1'b0;
    w_m_from_s  = 1'b0;
    w_load_s    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_state_nxt = ST_ONE;
          w_load_m    = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_acc && w_con) begin
          w_load_m = 1'b1;
        end else if (w_acc) begin
          w_state_nxt = ST_FULL;
          w_load_s    = 1'b1;
        end else if (w_con) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_con) begin
          w_state_nxt = ST_ONE;
          w_load_m    = 1'b1;
          w_m_from_s  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  assign w_m_nxt = w_m_from_s ? r_s : w_dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_m        <= '0;
      r_s        <= '0;
      // Preset high so the stage is ready in the very first cycle after reset;
      // the output is masked while reset is still asserted.
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
      if (w_load_m) begin
        r_m <= w_m_nxt;
      end
      if (w_load_s) begin
        r_s <= w_dec;
      end
    end
  end

  assign in_ready    = r_in_ready && !reset;
  assign out_valid   = (r_state != ST_EMPTY) && !reset;
  assign alu_in1     = r_m[31:0];
  assign alu_in2     = r_m[63:32];
  assign alu_funct3  = r_m[66:64];
  assign alu_funct7  = r_m[73:67];
  assign out_rd      = r_m[78:74];
  assign out_illegal = r_m[79];

endmodule

`default_nettype wire

// File: tb/tb_alu_op_issue.sv
// ============================================================================
// Module  : tb_alu_op_issue
// Brief   : Directed self-checking bench for alu_op_issue
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_issue;

  localparam logic [6:0] c_OP    = 7'b0110011;
  localparam logic [6:0] c_OPIMM = 7'b0010011;
  localparam logic [6:0] c_LOAD  = 7'b0000011;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int n_vec;
  int n_err;

  alu_op_issue dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_funct3  (alu_funct3),
    .alu_funct7  (alu_funct7),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_in1, input logic [31:0] e_in2,
                         input logic [2:0] e_f3, input logic [6:0] e_f7,
                         input logic [4:0] e_rd, input logic e_ill);
    chk({tag, ".valid"},   {31'd0, out_valid},   32'd1);
    chk({tag, ".in1"},     alu_in1,              e_in1);
    chk({tag, ".in2"},     alu_in2,              e_in2);
    chk({tag, ".funct3"},  {29'd0, alu_funct3},  {29'd0, e_f3});
    chk({tag, ".funct7"},  {25'd0, alu_funct7},  {25'd0, e_f7});
    chk({tag, ".rd"},      {27'd0, out_rd},      {27'd0, e_rd});
    chk({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, e_ill});
  endtask

  // Presents one instruction, lets it land in M, and leaves it on the outputs.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    instr    = ins;
    rs1_val  = a;
    rs2_val  = b;
    tick();
    in_valid = 1'b0;
    instr    = 32'hxxxxxxxx;
    rs1_val  = 32'hxxxxxxxx;
    rs2_val  = 32'hxxxxxxxx;
  endtask

  task automatic drain();
    tick();
    chk("drain.valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = 32'd0;
    rs1_val   = 32'd0;
    rs2_val   = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst.in1",       alu_in1,            32'd0);
    chk("rst.in2",       alu_in2,            32'd0);
    reset = 1'b0;
    #1;
    chk("rst.ready_after", {31'd0, in_ready}, 32'd1);

    // Single issues with out_ready high: decode checks
    out_ready = 1'b1;
    issue(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, c_OP), 32'd5, 32'd7);
    chk_out("add", 32'd5, 32'd7, 3'b000, 7'h00, 5'd3, 1'b0);
    drain();

    issue(r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd4, c_OP), 32'd5, 32'd7);
    chk_out("sub", 32'd5, 32'd7, 3'b000, 7'h20, 5'd4, 1'b0);
    drain();

    issue(i_type(12'hFFF, 5'd1, 3'b000, 5'd5, c_OPIMM), 32'd1, 32'h1234);
    chk_out("addi", 32'd1, 32'hFFFFFFFF, 3'b000, 7'h00, 5'd5, 1'b0);
    drain();

    issue(i_type(12'h41F, 5'd1, 3'b101, 5'd6, c_OPIMM), 32'h80000000, 32'h0);
    chk_out("srai", 32'h80000000, 32'd31, 3'b101, 7'h20, 5'd6, 1'b0);
    drain();

    issue(r_type(7'h00, 5'd2, 5'd1, 3'b001, 5'd7, c_OP), 32'h0000000F, 32'h00000123);
    chk_out("sll", 32'h0000000F, 32'd3, 3'b001, 7'h00, 5'd7, 1'b0);
    drain();

    issue(r_type(7'h00, 5'd2, 5'd1, 3'b101, 5'd12, c_OP), 32'h0000F000, 32'hFFFFFFE5);
    chk_out("srl", 32'h0000F000, 32'd5, 3'b101, 7'h00, 5'd12, 1'b0);
    drain();

    issue(i_type(12'h7FF, 5'd1, 3'b111, 5'd13, c_OPIMM), 32'h0000AAAA, 32'h0);
    chk_out("andi", 32'h0000AAAA, 32'h000007FF, 3'b111, 7'h00, 5'd13, 1'b0);
    drain();

    issue(i_type(12'h004, 5'd1, 3'b001, 5'd14, c_OPIMM), 32'h00000001, 32'h0);
    chk_out("slli", 32'h00000001, 32'd4, 3'b001, 7'h00, 5'd14, 1'b0);
    drain();

    // Illegal encodings
    issue(r_type(7'h00, 5'd2, 5'd1, 3'b010, 5'd8, c_OP), 32'hDEAD, 32'hBEEF);
    chk_out("ill.slt", 32'd0, 32'd0, 3'b000, 7'h00, 5'd8, 1'b1);
    drain();

    issue(i_type(12'h010, 5'd1, 3'b010, 5'd9, c_LOAD), 32'hDEAD, 32'hBEEF);
    chk_out("ill.load", 32'd0, 32'd0, 3'b000, 7'h00, 5'd9, 1'b1);
    drain();

    issue(i_type(12'h021, 5'd1, 3'b001, 5'd10, c_OPIMM), 32'hDEAD, 32'hBEEF);
    chk_out("ill.slli25", 32'd0, 32'd0, 3'b000, 7'h00, 5'd10, 1'b1);
    drain();

    issue(r_type(7'h20, 5'd2, 5'd1, 3'b100, 5'd11, c_OP), 32'hDEAD, 32'hBEEF);
    chk_out("ill.xor_alt", 32'd0, 32'd0, 3'b000, 7'h00, 5'd11, 1'b1);
    drain();

    // Back-pressure: four entries, out_ready low for three cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd1, c_OP);
    rs1_val   = 32'd101;
    rs2_val   = 32'd1;
    tick();
    chk("bp.ready_after1", {31'd0, in_ready}, 32'd1);
    chk_out("bp.e1_a", 32'd101, 32'd1, 3'b000, 7'h00, 5'd1, 1'b0);
    instr   = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd2, c_OP);
    rs1_val = 32'd102;
    rs2_val = 32'd2;
    tick();
    chk("bp.ready_after2", {31'd0, in_ready}, 32'd0);
    chk_out("bp.e1_b", 32'd101, 32'd1, 3'b000, 7'h00, 5'd1, 1'b0);
    instr   = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, c_OP);
    rs1_val = 32'd103;
    rs2_val = 32'd3;
    tick();
    chk("bp.ready_stall", {31'd0, in_ready}, 32'd0);
    chk_out("bp.e1_c", 32'd101, 32'd1, 3'b000, 7'h00, 5'd1, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_out("bp.e2", 32'd102, 32'd2, 3'b000, 7'h00, 5'd2, 1'b0);
    chk("bp.ready_release", {31'd0, in_ready}, 32'd1);
    tick();
    chk_out("bp.e3", 32'd103, 32'd3, 3'b000, 7'h00, 5'd3, 1'b0);
    instr   = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd4, c_OP);
    rs1_val = 32'd104;
    rs2_val = 32'd4;
    tick();
    chk_out("bp.e4", 32'd104, 32'd4, 3'b000, 7'h00, 5'd4, 1'b0);
    in_valid = 1'b0;
    drain();

    // Full throughput: 16 back-to-back entries
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      instr    = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'(k), c_OP);
      rs1_val  = 32'h1000 + 32'(k);
      rs2_val  = 32'(k);
      tick();
      chk("tp.valid", {31'd0, out_valid}, 32'd1);
      chk("tp.in1",   alu_in1,            32'h1000 + 32'(k));
      chk("tp.rd",    {27'd0, out_rd},    32'(k));
      chk("tp.ready", {31'd0, in_ready},  32'd1);
    end
    in_valid = 1'b0;
    drain();

    // Reset while FULL
    out_ready = 1'b0;
    issue(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd20, c_OP), 32'd200, 32'd0);
    issue(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd21, c_OP), 32'd201, 32'd0);
    chk("rf.full_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rf.valid_during", {31'd0, out_valid}, 32'd0);
    chk("rf.ready_during", {31'd0, in_ready},  32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rf.valid_after", {31'd0, out_valid}, 32'd0);
    chk("rf.ready_after", {31'd0, in_ready},  32'd1);
    chk("rf.in1_after",   alu_in1,            32'd0);
    out_ready = 1'b1;
    tick();
    chk("rf.no_stale1", {31'd0, out_valid}, 32'd0);
    tick();
    chk("rf.no_stale2", {31'd0, out_valid}, 32'd0);
    issue(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd22, c_OP), 32'd300, 32'd9);
    chk_out("rf.fresh", 32'd300, 32'd9, 3'b000, 7'h00, 5'd22, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_op_issue.md
# alu_op_issue

Decode-and-issue stage that sits in front of the integer ALU and drives its operand/function interface. Accepts one RV32I OP or OP-IMM instruction per cycle with its source register values over a valid/ready handshake. Produces the ALU's `in1`, `in2`, `funct3` and `funct7` through a two-entry skid buffer, so back-pressure from the execute stage never creates a combinational path to the decoder.

## Interface
- No parameters; all widths are fixed by the ALU interface (XLEN 32).
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `in_valid` in 1: upstream holds a valid instruction.
- `in_ready` out 1: stage can accept; a transfer occurs when `in_valid && in_ready`.
- `instr` in 32: instruction word.
- `rs1_val` in 32: rs1 register value.
- `rs2_val` in 32: rs2 register value.
- `out_valid` out 1: issue outputs hold a valid operation.
- `out_ready` in 1: execute stage consumes when `out_valid && out_ready`.
- `alu_in1` out 32: ALU operand 1.
- `alu_in2` out 32: ALU operand 2.
- `alu_funct3` out 3: ALU function select.
- `alu_funct7` out 7: ALU function modifier.
- `out_rd` out 5: destination register, `instr[11:7]`, passed through.
- `out_illegal` out 1: entry was not an ALU-supported encoding.

## Operation
- Decode is combinational on the input side. Its result is captured into the skid buffer on a transfer.
- OP (`instr[6:0]` = 0110011):
  - in1 = `rs1_val`; in2 = `rs2_val`; funct3 = `instr[14:12]`; funct7 = `instr[31:25]`.
  - Legal funct7 is 0000000 for funct3 ∈ {000, 001, 100, 101, 110, 111}.
  - Legal funct7 is 0100000 for funct3 ∈ {000, 101}.
- OP-IMM (`instr[6:0]` = 0010011):
  - in1 = `rs1_val`.
  - funct3 ∈ {000, 100, 110, 111}: in2 = sign-extended `instr[31:20]`; funct7 forced to 0000000.
  - funct3 = 001: in2 = zero-extended `instr[24:20]`; `instr[31:25]` must be 0000000; funct7 = 0000000.
  - funct3 = 101: in2 = zero-extended `instr[24:20]`; funct7 = `instr[31:25]`, which must be 0000000 or 0100000.
- Shift masking: for every shift (funct3 001/101), `alu_in2[31:5]` is forced to 0. The ALU shifts by the full `in2`, so RV32 low-5-bit semantics are enforced here.
- Illegal: any other opcode, funct3 010/011 (SLT/SLTU not supported by the ALU), or any funct7 violation above.
  - The entry is still issued with `out_illegal` = 1, in1 = in2 = 0, funct3 = 000, funct7 = 0000000.
  - The ALU therefore computes 0 + 0 = 0.
  - `out_rd` is still passed through.
- Skid buffer:
  - Main register M drives the outputs; skid register S holds one overflow entry.
  - States: EMPTY (M invalid), ONE (M valid, S invalid), FULL (both valid).
  - EMPTY: accept → ONE.
  - ONE: accept without consume → FULL (entry into S). Consume without accept → EMPTY. Accept and consume together → ONE (M replaced).
  - FULL: consume → ONE (S moves to M). `in_ready` = 0, so there is no accept.
- `in_ready` is a registered signal, equal to "next state ≠ FULL".
- Ordering is strict FIFO; no entry is dropped or duplicated.

## Timing
- Reset (synchronous): state EMPTY; `out_valid` = 0; `in_ready` = 0 while `reset` is high; all data outputs = 0.
- `in_ready` = 1 in the first cycle after `reset` deasserts.
- Latency: an entry accepted in cycle N is presented with `out_valid` = 1 in cycle N+1 if M was empty or consumed in N.
- Throughput: one entry per cycle with `out_ready` held high.
- Output stability: while `out_valid && !out_ready`, all outputs hold unchanged.
- Accepting into S never alters M.
- Simultaneous accept and consume in FULL cannot occur, because `in_ready` = 0.
- Simultaneous accept and consume in ONE: the new entry is in M next cycle and the state stays ONE.
- Reset mid-operation: the buffer is flushed with no output glitch; `out_valid` is 0 in the cycle after the reset edge.
- Inputs are sampled only on a transfer. `instr`, `rs1_val` and `rs2_val` are don't-care otherwise.

## Test plan
- ADD/SUB:
  - OP `add x3,x1,x2` with rs1 = 5, rs2 = 7 → next cycle in1 = 5, in2 = 7, funct3 = 000, funct7 = 0000000, rd = 3, illegal = 0.
  - `sub` → funct7 = 0100000.
- Immediates and shifts:
  - `addi` imm = 0xFFF with rs1 = 1 → in2 = 0xFFFFFFFF, funct7 = 0.
  - `srai` shamt = 31 → in2 = 31, funct7 = 0100000.
  - OP `sll` with rs2 = 0x00000123 → in2 = 0x00000003.
- Illegal encodings:
  - `slt`, opcode 0000011, `slli` with `instr[25]` = 1, OP funct3 = 100 with funct7 = 0100000 → each gives illegal = 1, in1 = in2 = 0, funct3 = funct7 = 0.
- Back-pressure: stream 4 entries with `out_ready` = 0 for 3 cycles.
  - `in_ready` drops after the 2nd accept.
  - M holds entry 1 stable.
  - On release, entries 1–4 emerge in order with no loss.
- Full throughput: 16 back-to-back entries with `out_ready` = 1 → one output per cycle, latency 1, `in_ready` constantly 1.
- Reset: assert `reset` in FULL for 1 cycle.
  - `out_valid` = 0 and `in_ready` = 0 during reset.
  - `in_ready` = 1 the next cycle.
  - No stale entry is ever issued.
